// File: rtl/aes_ctrl_stream.sv
// AES front-end controller: latches a job configuration, forwards data beats with
// valid/ready backpressure and attaches the per-lane ECB/CTR/CBC operand and keep mask.
module aes_ctrl_stream #(
    parameter int N_PIPES   = 4,
    parameter int KEY_WIDTH = 256,
    parameter int LEN_WIDTH = 32,
    localparam int W  = N_PIPES * 128,
    localparam int KW = W / 8,
    localparam int TW = $clog2(W / 8)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [1:0]           cfg_mode,
    input  logic                 cfg_op,
    input  logic [127:0]         cfg_iv,
    input  logic [KEY_WIDTH-1:0] cfg_key,
    input  logic [LEN_WIDTH-1:0] cfg_nbeats,
    input  logic [TW-1:0]        cfg_tail_bytes,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [W-1:0]         s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [W-1:0]         m_data,
    output logic [W-1:0]         m_cntr,
    output logic [KW-1:0]        m_keep,
    output logic                 m_last,
    output logic [KEY_WIDTH-1:0] m_key,
    output logic [2:0]           m_mode,
    input  logic                 fb_valid,
    input  logic [127:0]         fb_iv
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT_FB} state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   b_q, b_d, nbeats_q, nbeats_d;
    logic [TW-1:0]          tail_q, tail_d;
    logic [127:0]           iv_q, iv_d, chain_q, chain_d;
    logic                   m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [W-1:0]           m_data_q, m_data_d, m_cntr_q, m_cntr_d;
    logic [KW-1:0]          m_keep_q, m_keep_d;
    logic [KEY_WIDTH-1:0]   m_key_q, m_key_d;
    logic [2:0]             m_mode_q, m_mode_d;

    logic                   cfg_hs, s_hs, m_hs, is_ctr, is_cbc, is_dec, last_next;
    logic [63:0]            ctr_base;
    logic [W-1:0]           cntr_next;
    logic [KW-1:0]          keep_next;

    assign cfg_ready = (state_q == ST_IDLE);
    // Once every beat of the job has been accepted, input stays closed until the job drains.
    assign s_ready   = (state_q == ST_RUN) && (b_q < nbeats_q) && (!m_valid_q || m_ready);
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign s_hs      = s_valid && s_ready;
    assign m_hs      = m_valid_q && m_ready;
    assign is_ctr    = (m_mode_q[1:0] == 2'd1);
    assign is_cbc    = (m_mode_q[1:0] == 2'd2);
    assign is_dec    = m_mode_q[2];
    assign last_next = (b_q == nbeats_q - LEN_WIDTH'(1));
    assign ctr_base  = iv_q[63:0] + 64'(b_q) * 64'(N_PIPES);

    for (genvar gi = 0; gi < N_PIPES; gi++) begin : g_lane
        logic [127:0] cbc_op;
        if (gi == 0) begin : g_first
            assign cbc_op = chain_q;
        end else begin : g_rest
            assign cbc_op = s_data[128*(gi-1) +: 128];
        end
        // Counter wraps within the low 64 bits; the nonce half never sees a carry.
        assign cntr_next[128*gi +: 128] = is_ctr ? {iv_q[127:64], ctr_base + 64'(gi)} :
                                          is_cbc ? cbc_op : 128'd0;
    end

    for (genvar gi = 0; gi < KW; gi++) begin : g_keep
        assign keep_next[gi] = !last_next || (tail_q == '0) || (TW'(gi) < tail_q);
    end

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        nbeats_d  = nbeats_q;
        tail_d    = tail_q;
        iv_d      = iv_q;
        chain_d   = chain_q;
        m_valid_d = m_hs ? 1'b0 : m_valid_q;
        m_data_d  = m_data_q;
        m_cntr_d  = m_cntr_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        m_key_d   = m_key_q;
        m_mode_d  = m_mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_hs) begin
                    m_key_d  = cfg_key;
                    m_mode_d = {cfg_op, cfg_mode};
                    iv_d     = cfg_iv;
                    chain_d  = cfg_iv;
                    nbeats_d = cfg_nbeats;
                    tail_d   = cfg_tail_bytes;
                    b_d      = '0;
                    if (cfg_nbeats != '0) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (s_hs) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                    m_cntr_d  = cntr_next;
                    m_keep_d  = keep_next;
                    m_last_d  = last_next;
                    b_d       = b_q + LEN_WIDTH'(1);
                    if (is_cbc && is_dec)  chain_d = s_data[W-1 -: 128];
                    if (is_cbc && !is_dec) state_d = ST_WAIT_FB;
                end else if (m_hs && m_last_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_FB: begin
                if (fb_valid) begin
                    chain_d = fb_iv;
                    // Finish directly only if the final beat has already left (or leaves now).
                    if (b_q == nbeats_q && (!m_valid_q || m_hs)) state_d = ST_IDLE;
                    else                                          state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            b_q       <= '0;
            nbeats_q  <= '0;
            tail_q    <= '0;
            iv_q      <= '0;
            chain_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_cntr_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            m_key_q   <= '0;
            m_mode_q  <= '0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            nbeats_q  <= nbeats_d;
            tail_q    <= tail_d;
            iv_q      <= iv_d;
            chain_q   <= chain_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_cntr_q  <= m_cntr_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            m_key_q   <= m_key_d;
            m_mode_q  <= m_mode_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_cntr  = m_cntr_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;
    assign m_key   = m_key_q;
    assign m_mode  = m_mode_q;
endmodule

// File: doc/aes_ctrl_stream.md
# aes_ctrl_stream

Parametrised AES front-end controller that sits between the host data stream and the N-lane AES pipeline. It latches a per-job configuration (mode, direction, key, IV/nonce, length), then forwards data beats with full valid/ready backpressure. Alongside each beat it generates the per-lane counter/chaining operand for ECB, CTR or CBC, selected at run time. It also marks the last beat with a byte-accurate keep mask.

## Interface
Parameters:
- N_PIPES, 4, AES lanes per beat (1..8); beat width W = N_PIPES*128
- KEY_WIDTH, 256, width of key port (128/192/256; key is right-aligned)
- LEN_WIDTH, 32, width of beat-count field

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cfg_valid  in  1  job configuration valid
- cfg_ready  out  1  configuration accepted when both high
- cfg_mode  in  2  0 ECB, 1 CTR, 2 CBC (3 treated as ECB)
- cfg_op  in  1  0 encrypt, 1 decrypt
- cfg_iv  in  128  CBC IV; CTR initial block {nonce[127:64], ctr[63:0]}
- cfg_key  in  KEY_WIDTH  job key
- cfg_nbeats  in  LEN_WIDTH  beats in job
- cfg_tail_bytes  in  $clog2(W/8)  valid bytes in last beat; 0 = full
- s_valid, s_ready  in/out  1  input data handshake
- s_data  in  W  plaintext/ciphertext beat
- m_valid, m_ready  out/in  1  output handshake to AES core
- m_data  out  W  registered data
- m_cntr  out  W  per-lane operand, lane i = bits [128*i +: 128]
- m_keep  out  W/8  byte enables
- m_last  out  1  last beat of job
- m_key  out  KEY_WIDTH  latched key
- m_mode  out  3  {cfg_op, cfg_mode} latched
- fb_valid  in  1  CBC-encrypt chaining feedback valid
- fb_iv  in  128  last ciphertext block from core

## Operation
- States: IDLE, RUN, WAIT_FB.
- IDLE: cfg_ready=1. On cfg handshake: latch all cfg fields, beat index b=0, chain=cfg_iv. If cfg_nbeats==0 stay IDLE (no output), else go to RUN.
- RUN: s_ready = !m_valid || m_ready. On input handshake, the output register loads m_data=s_data, m_cntr, m_keep, m_last=(b==nbeats-1), and m_valid=1; b increments.
- Output register holds all m_* stable while m_valid && !m_ready.
- ECB: m_cntr = 0.
- CTR: lane i = {iv[127:64], (iv[63:0] + b*N_PIPES + i) mod 2^64}; no carry into nonce.
- CBC: lane 0 = chain; lane i>0 = s_data lane i-1.
- CBC decrypt: on input handshake, chain <= s_data top lane.
- CBC encrypt: after each input handshake, s_ready=0 and state goes to WAIT_FB. WAIT_FB exits on fb_valid: chain <= fb_iv, return to RUN (or IDLE if that beat was last).
- fb_valid is ignored outside WAIT_FB.
- m_keep is all ones, except on the last beat when tail_bytes!=0: low tail_bytes bits set.
- Job end: on the m_valid&&m_ready handshake of the m_last beat (and feedback already received in CBC-enc), return to IDLE. cfg_ready=0 throughout RUN/WAIT_FB.
- Asynchronous reset at any time aborts the job; all state returns to reset values.

## Timing
- Reset values: cfg_ready=1, s_ready=0, m_valid=0, m_last=0, m_data/m_cntr/m_keep/m_key/m_mode=0, state IDLE, b=0, chain=0.
- Config-to-s_ready: 1 cycle (s_ready can first be high the cycle after the cfg handshake).
- Input-to-output latency: 1 cycle. Full throughput of 1 beat/cycle in ECB, CTR and CBC-dec when m_ready=1.
- Simultaneous m_ready and s_valid with m_valid=1: the old beat drains and the new beat loads in the same cycle.
- CBC-enc throughput: one beat per (1 + feedback latency) cycles. fb_valid in the cycle after entry to WAIT_FB gives s_ready=1 the following cycle.
- Counter arithmetic is 64-bit; b is LEN_WIDTH bits and is zero-extended.

## Test plan
- CTR, N_PIPES=4, iv={64'hA5, 64'hFFFF_FFFF_FFFF_FFFE}, nbeats=2 -> beat0 lane ctr FFFE, FFFF, 0000, 0001; beat1 lanes 2..5; nonce stays A5; m_last only on beat1.
- ECB, nbeats=3, m_ready toggled 1-0-0-1 -> no beat lost or duplicated; m_data stable while stalled; s_ready low during stall.
- CBC-enc, nbeats=2, fb_valid 5 cycles after beat0 with fb_iv=X -> beat1 lane0 = X; s_ready stays 0 until the cycle after fb_valid.
- CBC-dec, nbeats=3 back-to-back -> beat k lane0 = top lane of beat k-1 (beat0 = cfg_iv); 3 beats output in 3 consecutive cycles.
- tail_bytes=5, nbeats=1 -> m_keep=64'h1F with m_last=1; cfg_nbeats=0 -> no m_valid, cfg_ready stays 1.
- resetn low mid-job (after beat1 of 4) -> all outputs go to reset values immediately; a new cfg after reset starts at b=0.
